matrix_3_3_reader: RTL
======================

Name: matrix_3_3_reader

Overview:
Read-side sequencer for the 3x3 byte matrix register file. On `start` it drives the storage's synchronous read port (row/col in, registered data_out back) and streams all nine elements out over a valid/ready interface. Order is row-major, or column-major when `transpose` is set. It sits between the matrix storage and the downstream multiplier or output FSM. It is the reading counterpart to the FSM that loads the matrix.

Parameters:
DATA_W, 8, element width in bits; must match the storage data width.
DIM, 3, matrix dimension; row/col counters run 0..DIM-1 and the address is 2 bits wide.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to begin a 9-element read; sampled only in IDLE.
transpose  in  1  order select, sampled with `start`: 0 = row-major, 1 = column-major.
abort  in  1  synchronous cancel; return to IDLE without `done`.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last element handshake.
mat_row  out  2  row address to storage.
mat_col  out  2  column address to storage.
mat_data  in  DATA_W  storage data_out, valid the cycle after the address edge.
out_valid  out  1  out_data, out_row, out_col and out_last are valid.
out_ready  in  1  downstream accepts the element.
out_data  out  DATA_W  element value.
out_row  out  2  row index of the element.
out_col  out  2  column index of the element.
out_last  out  1  high with the 9th element.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0: busy, done, mat_row, mat_col, out_valid, out_data, out_row, out_col, out_last. The latched order flag is 0.
- FSM states: IDLE, FETCH, CAPTURE, SEND.
  - IDLE: on start=1, latch `transpose`, set the address to (0,0), go to FETCH.
  - FETCH: mat_row/mat_col are stable. Storage samples them at this edge. Go to CAPTURE.
  - CAPTURE: mat_data is valid. At the edge, register mat_data into out_data, copy the address into out_row/out_col, set out_last = (address is the final one), set out_valid=1, go to SEND.
  - SEND: hold all out_* stable while out_ready=0. On out_valid & out_ready:
    - out_valid drops.
    - If out_last: go to IDLE and pulse done=1 for one cycle.
    - Otherwise: advance the address, go to FETCH.
- Address advance:
  - Row-major: col++; when col wraps from DIM-1 to 0, row++.
  - Column-major: row++; when row wraps, col++.
  - The final address is (2,2) in both orders. The counter never reaches index 3.
- Latency: 2 cycles from start to out_valid. Best-case throughput is one element per 3 cycles. Full read with out_ready tied high: start, then done 27 cycles later.
- Handshake: out_valid never drops without an accepting handshake, except on abort or reset. out_ready while out_valid=0 is ignored.
- start while busy: ignored. A mid-stream change of `transpose` is ignored.
- abort (any non-IDLE state): next edge goes to IDLE, clears out_valid and out_last, no done pulse. abort in IDLE is a no-op. abort together with start in IDLE: abort wins and the block stays IDLE.
- Reset mid-operation: immediate return to IDLE; the read is not resumed.
- The block never writes storage. The top level must hold the storage write enable low while busy=1. Coherency with concurrent writes is not guaranteed.
- done and out_valid are never high in the same cycle.

Decomposition:
- Shared package matrix_pkg: DATA_W, DIM, the 2-bit index type, the FSM state enum, and a constant LAST_IDX=2.
- Natural sub-module: matrix_idx_counter. It holds the row/col counter with a `transpose` order select, `clear`/`advance` inputs and a `last` flag. The same counter is reusable by the loader FSM.

Test Plan:
- Storage preloaded with element(r,c) = 3r+c+1; start, transpose=0, out_ready=1 -> out_data sequence 1,2,3,4,5,6,7,8,9; out_last only with 9; done exactly 27 cycles after start.
- Same matrix, transpose=1 -> sequence 1,4,7,2,5,8,3,6,9; (out_row,out_col) = (0,0),(1,0),(2,0),(0,1)...(2,2).
- out_ready low for 5 cycles at element 4 -> out_data=4, row=1, col=0 held stable the whole time; no address advance; the stream then resumes with 5.
- abort during SEND of element 6 -> out_valid=0 next cycle, busy=0, done never pulses; a subsequent start restarts from element 1.
- start pulsed again while busy, and transpose toggled mid-stream -> no effect; exactly 9 elements in the original order.
- rst_n asserted in CAPTURE -> all outputs 0 asynchronously; after release, IDLE until the next start.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 byte matrix register file and its sequencers.
//   DATA_W   : element width in bits (must match storage data width)
//   DIM      : matrix dimension; row/col indices run 0..DIM-1
//   idx_t    : 2-bit row/column index
//   LAST_IDX : highest index value on either axis
//   state_e  : read sequencer FSM states
package matrix_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIM    = 3;

    typedef logic [1:0] idx_t;

    localparam idx_t LAST_IDX = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCapture,
        StSend
    } state_e;

endpackage

// File: rtl/matrix_idx_counter.sv
// Row/column index counter for walking a DIM x DIM matrix in row-major or
// column-major order. Shared by the loader and reader sequencers.
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset, index returns to (0,0)
//   clear_i     : synchronous return to (0,0); wins over advance_i
//   advance_i   : step to the next index in the selected order
//   transpose_i : 0 = row-major (col fastest), 1 = column-major (row fastest)
//   row_o/col_o : current index
//   last_o      : current index is the final element (DIM-1, DIM-1)
module matrix_idx_counter #(
    parameter int unsigned DIM = matrix_pkg::DIM
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       advance_i,
    input  logic       transpose_i,
    output logic [1:0] row_o,
    output logic [1:0] col_o,
    output logic       last_o
);
    import matrix_pkg::*;

    localparam idx_t WrapIdx = idx_t'(DIM - 1);

    idx_t row_q, row_d;
    idx_t col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (!transpose_i) begin
                if (col_q == WrapIdx) begin
                    col_d = '0;
                    row_d = (row_q == WrapIdx) ? '0 : row_q + 2'd1;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end else begin
                if (row_q == WrapIdx) begin
                    row_d = '0;
                    col_d = (col_q == WrapIdx) ? '0 : col_q + 2'd1;
                end else begin
                    row_d = row_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == WrapIdx) && (col_q == WrapIdx);

endmodule

// File: rtl/matrix_3_3_reader.sv
// Read-side sequencer for the 3x3 matrix register file. On start it walks the
// storage's synchronous read port and streams all nine elements over a
// valid/ready interface, row-major or column-major (transpose).
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   start, transpose     : begin a read; order sampled with start in IDLE
//   abort                : synchronous cancel back to IDLE, no done
//   busy, done           : not-IDLE flag; one-cycle pulse after last handshake
//   mat_row, mat_col     : read address to storage
//   mat_data             : storage read data, valid the cycle after the address edge
//   out_valid, out_ready : element handshake
//   out_data, out_row, out_col, out_last : element payload
module matrix_3_3_reader #(
    parameter int unsigned DATA_W = matrix_pkg::DATA_W,
    parameter int unsigned DIM    = matrix_pkg::DIM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              transpose,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [1:0]        mat_row,
    output logic [1:0]        mat_col,
    input  logic [DATA_W-1:0] mat_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_row,
    output logic [1:0]        out_col,
    output logic              out_last
);
    import matrix_pkg::*;

    state_e            state_q;
    logic              order_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic              last_q;
    logic [DATA_W-1:0] data_q;
    idx_t              row_q;
    idx_t              col_q;

    idx_t idx_row;
    idx_t idx_col;
    logic idx_last;
    logic idx_clear;
    logic idx_advance;

    // abort blocks both counter moves so an aborted read leaves the index untouched
    assign idx_clear   = (state_q == StIdle) && start && !abort;
    assign idx_advance = (state_q == StSend) && out_ready && !last_q && !abort;

    matrix_idx_counter #(
        .DIM(DIM)
    ) u_idx (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (idx_clear),
        .advance_i  (idx_advance),
        .transpose_i(order_q),
        .row_o      (idx_row),
        .col_o      (idx_col),
        .last_o     (idx_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            order_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            order_q <= transpose;
                            busy_q  <= 1'b1;
                            state_q <= StFetch;
                        end
                    end
                    // Storage samples the address at the end of this cycle.
                    StFetch: state_q <= StCapture;
                    StCapture: begin
                        data_q  <= mat_data;
                        row_q   <= idx_row;
                        col_q   <= idx_col;
                        last_q  <= idx_last;
                        valid_q <= 1'b1;
                        state_q <= StSend;
                    end
                    StSend: begin
                        if (out_ready) begin
                            valid_q <= 1'b0;
                            if (last_q) begin
                                last_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                state_q <= StFetch;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mat_row   = idx_row;
    assign mat_col   = idx_col;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;

endmodule
